// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: PC-register link, instruction-memory port and IF/ID outputs.
interface fetch_unit_if;
  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] pc_in;
  logic [XLEN-1:0] pc_next;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            instr_valid;
  logic [XLEN-1:0] instr_out;
  logic [XLEN-1:0] instr_pc;
  logic [XLEN-1:0] instr_pc4;
  logic            fetch_fault;

  modport master (
    input  pc_in,
    output pc_next,
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    input  stall,
    input  redirect_valid,
    input  redirect_target,
    output instr_valid,
    output instr_out,
    output instr_pc,
    output instr_pc4,
    output fetch_fault
  );

  modport slave (
    output pc_in,
    input  pc_next,
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    output stall,
    output redirect_valid,
    output redirect_target,
    input  instr_valid,
    input  instr_out,
    input  instr_pc,
    input  instr_pc4,
    input  fetch_fault
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: next-PC select, imem request sequencing, IF/ID register with skid.
// Optional macro FETCH_FAULT_EN adds misaligned-redirect and ack-timeout fault detection.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {IDLE, REQ, HOLD, DROP, FAULT} state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } entry_t;

  state_t          r_state, w_state_nxt;
  logic            r_req, w_req_nxt;
  logic [XLEN-1:0] r_addr, w_addr_nxt;
  logic            r_valid, w_valid_nxt;
  entry_t          r_out, w_out_nxt;
  entry_t          r_skid, w_skid_nxt;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_pc_inc;
  logic [XLEN-1:0] w_target;
  entry_t          w_fetched;
  logic            w_fault_hold;
  logic            w_fault_set;

`ifdef FETCH_FAULT_EN
  localparam int unsigned CW = $clog2(MAX_WAIT + 2);

  logic          r_fault;
  logic [CW-1:0] r_wait_cnt;

  assign w_target     = bus.redirect_target;
  assign w_fault_hold = r_fault;
  assign w_fault_set  = !r_fault &&
                        ((bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00)) ||
                         (r_req && !bus.imem_ack && (r_wait_cnt == CW'(MAX_WAIT))));

  // Sticky fault flag and saturating count of cycles spent waiting for an ack
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fault    <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      if (w_fault_set) r_fault <= 1'b1;
      if (r_req && !bus.imem_ack) begin
        if (r_wait_cnt != CW'(MAX_WAIT)) r_wait_cnt <= r_wait_cnt + CW'(1);
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  assign bus.fetch_fault = r_fault;
`else
  logic w_unused;

  assign w_target        = {bus.redirect_target[XLEN-1:2], 2'b00};
  assign w_fault_hold    = 1'b0;
  assign w_fault_set     = 1'b0;
  assign w_unused        = ^{bus.redirect_target[1:0], 32'(MAX_WAIT)};
  assign bus.fetch_fault = 1'b0;
`endif

  assign w_pc_inc  = bus.pc_in + XLEN'(4);
  assign w_fetched = '{instr: bus.imem_rdata, pc: r_addr, pc4: r_addr + XLEN'(4)};

  // Next-state, next-PC and IF/ID update; redirect outranks everything but a fault
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_addr_nxt  = r_addr;
    w_valid_nxt = r_valid;
    w_out_nxt   = r_out;
    w_skid_nxt  = r_skid;
    w_pc_next   = bus.pc_in;

    if (r_valid && !bus.stall) w_valid_nxt = 1'b0;

    if (w_fault_hold || w_fault_set) begin
      w_state_nxt = FAULT;
      w_req_nxt   = 1'b0;
      w_valid_nxt = 1'b0;
    end else if (bus.redirect_valid) begin
      w_valid_nxt = 1'b0;
      w_pc_next   = w_target;
      if (r_req && !bus.imem_ack) begin
        w_state_nxt = DROP;
      end else begin
        w_state_nxt = REQ;
        w_req_nxt   = 1'b1;
        w_addr_nxt  = w_target;
      end
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_nxt = REQ;
          w_req_nxt   = 1'b1;
          w_addr_nxt  = bus.pc_in;
        end
        REQ: begin
          if (bus.imem_ack) begin
            w_pc_next = w_pc_inc;
            if (!r_valid || !bus.stall) begin
              w_out_nxt   = w_fetched;
              w_valid_nxt = 1'b1;
              w_addr_nxt  = w_pc_inc;
            end else begin
              w_skid_nxt  = w_fetched;
              w_state_nxt = HOLD;
              w_req_nxt   = 1'b0;
            end
          end
        end
        HOLD: begin
          if (!bus.stall) begin
            w_out_nxt   = r_skid;
            w_valid_nxt = 1'b1;
            w_state_nxt = REQ;
            w_req_nxt   = 1'b1;
            w_addr_nxt  = bus.pc_in;
          end
        end
        DROP: begin
          if (bus.imem_ack) begin
            w_state_nxt = REQ;
            w_req_nxt   = 1'b1;
            w_addr_nxt  = bus.pc_in;
          end
        end
        FAULT: begin
          w_req_nxt   = 1'b0;
          w_valid_nxt = 1'b0;
        end
        default: begin
          w_state_nxt = IDLE;
          w_req_nxt   = 1'b0;
        end
      endcase
    end

    if (!reset) w_pc_next = RESET_PC;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_out   <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_addr  <= w_addr_nxt;
      r_valid <= w_valid_nxt;
      r_out   <= w_out_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  assign bus.pc_next     = w_pc_next;
  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = r_addr;
  assign bus.instr_valid = r_valid;
  assign bus.instr_out   = r_out.instr;
  assign bus.instr_pc    = r_out.pc;
  assign bus.instr_pc4   = r_out.pc4;

endmodule
